// File: rtl/sram_1r1w_model.sv
// Single-clock 1R1W synchronous SRAM behavioural model with registered read data and simulation backdoor.
// Optional macro SRAM_WRITE_FORWARD_EN selects write-first on same-address collisions (default: read-before-write).
module sram_1r1w_model #(
    parameter int DATA_W = 512,
    parameter int DEPTH  = 1728,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              csb,
    input  logic              wsb,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    logic waddr_ok;
    logic raddr_ok;
    logic do_write;
    logic do_read;

    always_comb begin
        waddr_ok = ({1'b0, waddr} < DEPTH_L);
        raddr_ok = ({1'b0, raddr} < DEPTH_L);
        do_write = !csb && !wsb && waddr_ok;
        do_read  = !csb;
    end

    // Storage is never reset so preloaded images survive a reset pulse.
    always_ff @(posedge clk) begin
        if (!rst && do_write) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (do_read) begin
            if (!raddr_ok) begin
                rdata <= '0;
`ifdef SRAM_WRITE_FORWARD_EN
            end else if (do_write && (waddr == raddr)) begin
                rdata <= wdata;
`endif
            end else begin
                rdata <= mem[raddr];
            end
        end
    end

`ifndef SYNTHESIS
    // Zero-delay backdoor access, bypassing csb, wsb and rst.
    task automatic load_param(input int index, input logic [DATA_W-1:0] data);
        if (index < 0 || index >= DEPTH) begin
            $display("sram_1r1w_model: load_param index %0d out of range, ignored", index);
        end else begin
            mem[index[ADDR_W-1:0]] = data;
        end
    endtask

    task automatic dump_param(input int index, output logic [DATA_W-1:0] data);
        if (index < 0 || index >= DEPTH) begin
            data = '0;
        end else begin
            data = mem[index[ADDR_W-1:0]];
        end
    endtask
`endif

endmodule

// File: tb/tb_sram_1r1w_model.sv
// Directed self-checking bench for sram_1r1w_model: default 512-bit instance plus a 99-bit instance sweep.
module tb_sram_1r1w_model;

    localparam int W   = 512;
    localparam int W99 = 99;
    localparam int D   = 1728;
    localparam int AW  = 11;

    logic          clk = 1'b0;
    logic          rst;
    logic          csb;
    logic          wsb;
    logic [AW-1:0] waddr;
    logic [W-1:0]  wdata;
    logic [AW-1:0] raddr;
    logic [W-1:0]  rdata;

    logic          csb99;
    logic          wsb99;
    logic [AW-1:0] waddr99;
    logic [W99-1:0] wdata99;
    logic [AW-1:0] raddr99;
    logic [W99-1:0] rdata99;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sram_1r1w_model #(.DATA_W(W), .DEPTH(D), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .csb(csb), .wsb(wsb),
        .waddr(waddr), .wdata(wdata), .raddr(raddr), .rdata(rdata)
    );

    sram_1r1w_model #(.DATA_W(W99), .DEPTH(D), .ADDR_W(AW)) dut99 (
        .clk(clk), .rst(rst), .csb(csb99), .wsb(wsb99),
        .waddr(waddr99), .wdata(wdata99), .raddr(raddr99), .rdata(rdata99)
    );

    // Advance past one rising edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W99-1:0] pattern99(input int r);
        logic [31:0] a;
        logic [31:0] b;
        logic [34:0] c;
        a = 32'(r * 7919 + 13);
        b = ~32'(r);
        c = 35'(r) << 3;
        return {a, b, c};
    endfunction

    task automatic test_reset();
        rst = 1'b1; csb = 1'b1; wsb = 1'b1; waddr = '0; wdata = '0; raddr = '0;
        csb99 = 1'b1; wsb99 = 1'b1; waddr99 = '0; wdata99 = '0; raddr99 = '0;
        #1;
        checks++;
        if (rdata !== '0) begin
            errors++;
            $display("[TB] FAIL reset_rdata: got %h expected 0", rdata);
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (rdata !== '0) begin
            errors++;
            $display("[TB] FAIL reset_release_rdata: got %h expected 0", rdata);
        end
    endtask

    task automatic test_backdoor();
        logic [W-1:0] exp;
        logic [W-1:0] got;
        exp = {64{8'hA5}};
        dut.load_param(5, exp);
        raddr = 11'd5; csb = 1'b0; wsb = 1'b1;
        #1;
        checks++;
        if (rdata !== '0) begin
            errors++;
            $display("[TB] FAIL backdoor_pre_edge: got %h expected 0", rdata);
        end
        tick();
        checks++;
        if (rdata !== exp) begin
            errors++;
            $display("[TB] FAIL backdoor_read: got %h expected %h", rdata, exp);
        end
        dut.dump_param(5, got);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL dump_in_range: got %h expected %h", got, exp);
        end
        dut.dump_param(1800, got);
        checks++;
        if (got !== '0) begin
            errors++;
            $display("[TB] FAIL dump_out_of_range: got %h expected 0", got);
        end
    endtask

    task automatic test_write_read();
        csb = 1'b0; wsb = 1'b0; waddr = 11'd1727; wdata = 512'h1234; raddr = 11'd5;
        tick();
        wsb = 1'b1; raddr = 11'd1727;
        tick();
        checks++;
        if (rdata !== 512'h1234) begin
            errors++;
            $display("[TB] FAIL write_read_rdata: got %h expected 1234", rdata);
        end
        checks++;
        if (dut.mem[1727] !== 512'h1234) begin
            errors++;
            $display("[TB] FAIL write_read_mem: got %h expected 1234", dut.mem[1727]);
        end
    endtask

    task automatic test_read_during_write();
        logic [W-1:0] exp_first;
`ifdef SRAM_WRITE_FORWARD_EN
        exp_first = 512'h2;
`else
        exp_first = 512'h1;
`endif
        dut.load_param(10, 512'h1);
        csb = 1'b0; wsb = 1'b0; waddr = 11'd10; raddr = 11'd10; wdata = 512'h2;
        tick();
        wsb = 1'b1;
        checks++;
        if (rdata !== exp_first) begin
            errors++;
            $display("[TB] FAIL rdw_same_cycle: got %h expected %h", rdata, exp_first);
        end
        tick();
        checks++;
        if (rdata !== 512'h2) begin
            errors++;
            $display("[TB] FAIL rdw_repeat_read: got %h expected 2", rdata);
        end
    endtask

    task automatic test_independent();
        csb = 1'b0; wsb = 1'b0; waddr = 11'd20; wdata = 512'hBEEF; raddr = 11'd5;
        tick();
        wsb = 1'b1;
        checks++;
        if (rdata !== {64{8'hA5}}) begin
            errors++;
            $display("[TB] FAIL indep_read: got %h expected a5..a5", rdata);
        end
        checks++;
        if (dut.mem[20] !== 512'hBEEF) begin
            errors++;
            $display("[TB] FAIL indep_write: got %h expected beef", dut.mem[20]);
        end
    endtask

    task automatic test_out_of_range();
        dut.load_param(72, 512'h0);
        dut.load_param(776, 512'h0);
        dut.load_param(1800, 512'hDEAD);
        csb = 1'b0; wsb = 1'b0; waddr = 11'd1800; wdata = 512'hFF; raddr = 11'd5;
        tick();
        wsb = 1'b1;
        checks++;
        if (dut.mem[1727] !== 512'h1234 || dut.mem[72] !== 512'h0 || dut.mem[776] !== 512'h0
            || dut.mem[10] !== 512'h2 || dut.mem[5] !== {64{8'hA5}}) begin
            errors++;
            $display("[TB] FAIL oor_write: mem[1727]=%h mem[72]=%h mem[776]=%h mem[10]=%h expected 1234/0/0/2",
                     dut.mem[1727], dut.mem[72], dut.mem[776], dut.mem[10]);
        end
        raddr = 11'd1800;
        tick();
        checks++;
        if (rdata !== '0) begin
            errors++;
            $display("[TB] FAIL oor_read: got %h expected 0", rdata);
        end
    endtask

    task automatic test_reset_csb();
        dut.load_param(0, 512'h7);
        csb = 1'b0; wsb = 1'b1; raddr = 11'd0;
        tick();
        checks++;
        if (rdata !== 512'h7) begin
            errors++;
            $display("[TB] FAIL preload_read: got %h expected 7", rdata);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (rdata !== '0) begin
            errors++;
            $display("[TB] FAIL async_reset: got %h expected 0", rdata);
        end
        wsb = 1'b0; waddr = 11'd0; wdata = 512'h9;
        tick();
        checks++;
        if (rdata !== '0 || dut.mem[0] !== 512'h7) begin
            errors++;
            $display("[TB] FAIL write_in_reset: rdata=%h mem[0]=%h expected 0/7", rdata, dut.mem[0]);
        end
        rst = 1'b0; wsb = 1'b1;
        tick();
        checks++;
        if (rdata !== 512'h7) begin
            errors++;
            $display("[TB] FAIL read_after_reset: got %h expected 7", rdata);
        end
        csb = 1'b1; wsb = 1'b0; raddr = 11'd5; waddr = 11'd0; wdata = 512'h9;
        tick();
        tick();
        checks++;
        if (rdata !== 512'h7) begin
            errors++;
            $display("[TB] FAIL csb_hold: got %h expected 7", rdata);
        end
        checks++;
        if (dut.mem[0] !== 512'h7) begin
            errors++;
            $display("[TB] FAIL csb_write_ignored: got %h expected 7", dut.mem[0]);
        end
        wsb = 1'b1;
    endtask

    task automatic test_width99();
        int bad_rd;
        int bad_mem;
        bad_rd = 0;
        bad_mem = 0;
        csb99 = 1'b0; wsb99 = 1'b0;
        for (int r = 0; r < D; r++) begin
            waddr99 = AW'(r);
            wdata99 = pattern99(r);
            tick();
        end
        wsb99 = 1'b1;
        for (int r = 0; r < D; r++) begin
            raddr99 = AW'(r);
            tick();
            checks++;
            if (rdata99 !== pattern99(r)) begin
                errors++;
                if (bad_rd < 5) $display("[TB] FAIL w99_read[%0d]: got %h expected %h", r, rdata99, pattern99(r));
                bad_rd++;
            end
        end
        for (int r = 0; r < D; r++) begin
            checks++;
            if (dut99.mem[r] !== pattern99(r)) begin
                errors++;
                if (bad_mem < 5) $display("[TB] FAIL w99_mem[%0d]: got %h expected %h", r, dut99.mem[r], pattern99(r));
                bad_mem++;
            end
        end
        csb99 = 1'b1;
    endtask

    initial begin
        test_reset();
        test_backdoor();
        test_write_read();
        test_read_during_write();
        test_independent();
        test_out_of_range();
        test_reset_csb();
        test_width99();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sram_1r1w_model.md
Name: sram_1r1w_model

Overview:
- Parameterized single-clock, one-read/one-write synchronous SRAM model for the JPEG encoder datapath.
- Default configuration is the 1728-entry × 512-bit RGB/YCbCr buffer. The 1728 × 99-bit entropy-code buffer is the same block with DATA_W=99.
- Provides simulation backdoor load plus a hierarchically readable storage array, so benches can preload images and check results in memory directly.

Parameters:
- DATA_W, 512, word width in bits.
- DEPTH, 1728, number of words.
- ADDR_W, 11, address width; must satisfy 2^ADDR_W ≥ DEPTH.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous active-high reset.
- csb  input  1  chip select, active-low; when high, no read or write occurs.
- wsb  input  1  write enable, active-low; qualified by csb.
- waddr  input  ADDR_W  write address.
- wdata  input  DATA_W  write data.
- raddr  input  ADDR_W  read address.
- rdata  output  DATA_W  registered read data.

Behaviour:
- Storage:
  - Array named mem, indexed 0..DEPTH-1, DATA_W bits per word.
  - Benches access mem[i] hierarchically; the name is fixed.
- Reset:
  - rst asserted clears rdata to 0 immediately, without waiting for a clock edge.
  - mem contents are NOT cleared, so preloaded data survives reset.
  - While rst is high, no writes and no read-register updates occur.
  - Deassertion takes effect at the next rising edge.
- Write, at rising edge with rst=0, csb=0, wsb=0:
  - mem[waddr] <= wdata.
  - waddr ≥ DEPTH: write dropped, no other word modified.
- Read, at rising edge with rst=0 and csb=0:
  - rdata <= mem[raddr]; read latency is exactly 1 cycle.
  - Read is independent of wsb, so read and write can happen in the same cycle.
  - raddr ≥ DEPTH: rdata <= 0.
- csb=1: rdata holds its previous value; mem is unchanged.
- Same-cycle read and write to the same address (default build):
  - rdata returns the OLD contents (read-before-write).
  - The new value is visible on a read issued the following cycle.
- Simultaneous reads and writes to different addresses are fully independent.
- Unwritten, unloaded words read as X in simulation; no initial clear.
- Backdoor task load_param(index, data), simulation only:
  - Performs mem[index] = data immediately, with zero delay.
  - Ignores csb, wsb and rst.
  - index ≥ DEPTH: ignored, with $display warning.
- Backdoor task dump_param(index, out data): returns mem[index]; returns 0 for out-of-range index.
- Block is a behavioural model, not synthesised. Pure RTL constructs only; no vendor primitives.

Optional Feature:
- Macro SRAM_WRITE_FORWARD_EN.
- Defined:
  - Same-cycle read and write to the same in-range address with csb=0, wsb=0 forwards wdata to rdata (write-first).
  - Behaviour for all other cases is unchanged.
- Undefined: read-before-write as specified above.

Test Plan:
- Backdoor load then frontdoor read:
  - load_param(5, 512'hA5..A5), then drive raddr=5, csb=0.
  - rdata = 512'hA5..A5 one cycle later, and 0 in the cycle before.
- Write then read:
  - Write 512'h1234 to addr 1727, then read addr 1727 next cycle.
  - rdata = 512'h1234; also mem[1727] = 512'h1234 hierarchically.
- Read-during-write at addr 10:
  - Setup: mem[10]=512'h1; write 512'h2 to addr 10 and read addr 10 in the same cycle.
  - Default build: rdata = 512'h1, then 512'h2 on a repeat read.
  - With SRAM_WRITE_FORWARD_EN: rdata = 512'h2 immediately.
- Out-of-range:
  - Write 512'hFF to addr 1800 → no mem word changes.
  - Read addr 1800 → rdata = 0.
- Reset and chip select:
  - Preload mem[0]=7 and read it so rdata=7, then pulse rst mid-cycle.
  - rdata = 0 asynchronously; a read of addr 0 after reset returns 7.
  - With csb=1, rdata holds its value and writes are ignored.
- 99-bit instance (DATA_W=99):
  - Sweep addresses 0..1727 with a write, then a readback of each.
  - Every word matches, and mem[r] equals the expected data for all r.
